// File: rtl/mem_pkt_sequencer.sv
// Replays a pre-loaded ctrl/data descriptor memory as an AXI-Stream master,
// with per-packet gaps, tready backpressure, packet limit and end-marker stop.
module mem_pkt_sequencer #(
    parameter int DATA_WIDTH = 64,
    parameter int MEM_DEPTH  = 16384
) (
    input  logic                    tx_mac_aclk,
    input  logic                    reset_,
    input  logic                    start,
    input  logic [31:0]             start_addr,
    input  logic [15:0]             pkt_limit,
    output logic [31:0]             mem_wr_address,
    input  logic [31:0]             mem_axis_wctrl,
    input  logic [DATA_WIDTH-1:0]   mem_axis_wdata,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             pkt_cnt,
    output logic                    err_trunc
);

    typedef enum logic [2:0] {S_IDLE, S_STREAM, S_GAP, S_DRAIN, S_DONE} state_t;

    state_t                  r_state, w_state_nxt;
    logic [31:0]             r_addr;
    logic [DATA_WIDTH-1:0]   r_tdata;
    logic [DATA_WIDTH/8-1:0] r_tkeep;
    logic                    r_tlast;
    logic                    r_tvalid;
    logic [15:0]             r_pkt_cnt;
    logic                    r_err;
    logic [15:0]             r_limit;
    logic [15:0]             r_ld_pkts;
    logic                    r_stop;
    logic                    r_gap_pend;
    logic [7:0]              r_gap;
    logic [7:0]              r_gap_cnt;
    logic                    r_last_ld;

    logic        w_hs;
    logic        w_slot;
    logic        w_entry_vld;
    logic        w_c_last;
    logic [7:0]  w_c_gap;
    logic        w_limit_hit;
    logic [31:0] w_addr_inc;
    logic        w_load;
    logic        w_start;
    logic        w_to_gap;
    logic        w_to_drain;
    logic        w_unused;

    assign w_hs        = r_tvalid && m_axis_tready;
    assign w_slot      = !r_tvalid || m_axis_tready;
    assign w_entry_vld = mem_axis_wctrl[31];
    assign w_c_last    = mem_axis_wctrl[30];
    assign w_c_gap     = mem_axis_wctrl[23:16];
    assign w_unused    = ^{mem_axis_wctrl[29:24], mem_axis_wctrl[15:8]};
    // Packet number pkt_limit is being loaded: freeze loading after it
    assign w_limit_hit = w_c_last && (r_limit != 16'd0) && (r_ld_pkts + 16'd1 == r_limit);
    assign w_addr_inc  = (r_addr >= 32'(MEM_DEPTH - 1)) ? 32'd0 : r_addr + 32'd1;

    always_ff @(posedge tx_mac_aclk or negedge reset_) begin
        if (!reset_) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_start     = 1'b0;
        w_to_gap    = 1'b0;
        w_to_drain  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (r_stop) begin
                    if (!r_tvalid || w_hs) w_state_nxt = S_DONE;
                end else if (r_gap_pend) begin
                    if (w_hs) begin
                        w_to_gap    = 1'b1;
                        w_state_nxt = S_GAP;
                    end
                end else if (w_slot) begin
                    if (w_entry_vld) begin
                        w_load = 1'b1;
                    end else begin
                        w_to_drain  = 1'b1;
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_GAP: begin
                // Load in the last gap cycle so tvalid rises right after it
                if (r_gap_cnt <= 8'd1) begin
                    if (w_entry_vld) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_STREAM;
                    end else begin
                        w_to_drain  = 1'b1;
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!r_tvalid || w_hs) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge tx_mac_aclk or negedge reset_) begin
        if (!reset_) begin
            r_addr     <= '0;
            r_tdata    <= '0;
            r_tkeep    <= '0;
            r_tlast    <= 1'b0;
            r_tvalid   <= 1'b0;
            r_pkt_cnt  <= '0;
            r_err      <= 1'b0;
            r_limit    <= '0;
            r_ld_pkts  <= '0;
            r_stop     <= 1'b0;
            r_gap_pend <= 1'b0;
            r_gap      <= '0;
            r_gap_cnt  <= '0;
            r_last_ld  <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr     <= start_addr;
                r_pkt_cnt  <= '0;
                r_err      <= 1'b0;
                r_limit    <= pkt_limit;
                r_ld_pkts  <= '0;
                r_stop     <= 1'b0;
                r_gap_pend <= 1'b0;
                r_last_ld  <= 1'b1;
            end
            if (w_hs && r_tlast && r_pkt_cnt != 16'hFFFF) r_pkt_cnt <= r_pkt_cnt + 16'd1;
            if (w_load) begin
                r_tdata    <= mem_axis_wdata;
                r_tkeep    <= mem_axis_wctrl[DATA_WIDTH/8-1:0];
                r_tlast    <= w_c_last;
                r_tvalid   <= 1'b1;
                r_addr     <= w_addr_inc;
                r_last_ld  <= w_c_last;
                r_ld_pkts  <= r_ld_pkts + {15'd0, w_c_last};
                r_stop     <= w_limit_hit;
                r_gap_pend <= w_c_last && (w_c_gap != 8'd0) && !w_limit_hit;
                r_gap      <= w_c_gap;
            end else if (w_hs) begin
                r_tvalid <= 1'b0;
            end
            if (w_to_gap) begin
                r_gap_cnt  <= r_gap;
                r_gap_pend <= 1'b0;
            end else if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt - 8'd1;
            end
            // Last loaded beat is the last one delivered once loading stops
            if (w_to_drain) r_err <= !r_last_ld;
        end
    end

    assign mem_wr_address = r_addr;
    assign m_axis_tdata   = r_tdata;
    assign m_axis_tkeep   = r_tkeep;
    assign m_axis_tlast   = r_tlast;
    assign m_axis_tvalid  = r_tvalid;
    assign busy           = (r_state == S_STREAM) || (r_state == S_GAP) || (r_state == S_DRAIN);
    assign done           = (r_state == S_DONE);
    assign pkt_cnt        = r_pkt_cnt;
    assign err_trunc      = r_err;

endmodule

// File: doc/mem_pkt_sequencer.md
Name: mem_pkt_sequencer

Overview:
- Walks a pre-loaded packet-descriptor memory (a 32-bit control word plus a DATA_WIDTH data word per address) and replays it as an AXI-Stream master toward the LMAC RX/TX datapath.
- Drives the memory read address and samples the combinational ctrl/data return.
- Applies per-packet inter-packet gaps, honours tready backpressure and stops at an end marker or a packet limit.

Parameters:
- DATA_WIDTH, 64, stream/data word width; fixed at 64 because the ctrl map carries an 8-bit keep field.
- MEM_DEPTH, 16384, number of memory entries; the address wraps modulo MEM_DEPTH.

Ports:
- tx_mac_aclk  in  1  clock; the single clock.
- reset_  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a run; ignored while busy=1.
- start_addr  in  32  first memory address of the run; sampled on start.
- pkt_limit  in  16  number of packets to send; 0 means unlimited (stop at end marker); sampled on start.
- mem_wr_address  out  32  memory read address.
- mem_axis_wctrl  in  32  ctrl word at mem_wr_address, combinational, same cycle.
- mem_axis_wdata  in  DATA_WIDTH  data word at mem_wr_address, combinational, same cycle.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tkeep  out  DATA_WIDTH/8  byte enables.
- m_axis_tlast  out  1  last beat of packet.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when a run completes.
- pkt_cnt  out  16  packets completed in the current run.
- err_trunc  out  1  sticky; end marker reached mid-packet; cleared on start.

Behaviour:
- Ctrl word map:
  - [31] entry valid; 0 = end marker.
  - [30] tlast.
  - [23:16] gap, in cycles, applied after this beat when tlast=1.
  - [7:0] tkeep.
  - All other bits are ignored.
- Reset (asynchronous, immediate, including mid-run): all outputs are 0, state IDLE, the output register is empty.
- States: IDLE, STREAM, GAP, DRAIN, DONE.
- IDLE:
  - busy=0, tvalid=0.
  - On start: mem_wr_address<=start_addr, pkt_cnt<=0, err_trunc<=0, limit latched, go to STREAM. busy=1 from the next cycle.
- STREAM:
  - A single output register holds the presented beat.
  - A load occurs in any cycle where the register is empty, or tvalid&&tready, and ctrl[31]=1 and no stop condition is pending.
  - On a load: tdata/tkeep/tlast are captured from the current address, address<=(address+1) mod MEM_DEPTH, and tvalid is 1 the following cycle.
  - Sustained throughput is 1 beat/cycle with tready=1. First tvalid appears 2 cycles after the start pulse.
- Stability: while tvalid=1 and tready=0, tdata/tkeep/tlast/tvalid hold unchanged.
- Packet count: a tlast handshake increments pkt_cnt (16-bit, saturates at 0xFFFF).
- Gap: if the loaded tlast beat has gap=N>0, no further load occurs until that beat handshakes. The block then enters GAP for N cycles.
  - With the tlast handshake at cycle t, the next tvalid rises at cycle t+N+1.
  - With N=0, the next beat follows back-to-back.
- Limit: if pkt_limit!=0 and the tlast beat just loaded is packet number pkt_limit, no further load occurs. After its handshake the block goes to DONE. The address stays at the entry after that beat.
- End marker: if ctrl[31]=0 when a load would occur, nothing is loaded and the address does not advance.
  - The block goes to DRAIN: it waits for any held beat to handshake, then goes to DONE.
  - If the last beat delivered had tlast=0, err_trunc<=1.
- Memory-length limit: a run longer than MEM_DEPTH beats is allowed and wraps; there is no error.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle, next state IDLE. pkt_cnt and err_trunc hold until the next start.
- Simultaneous events:
  - A start in the DONE cycle is ignored.
  - An end marker and the limit reached together count as limit; err_trunc=0.

Test Plan:
- Table 0..2 = one 3-beat packet (tkeep FF,FF,0F; tlast on beat 2), entry 3 = 0x00000000; start_addr=0, tready=1 -> tvalid cycles 2..4 after start, tlast on the 3rd beat, pkt_cnt=1, done pulse, err_trunc=0.
- Same table with tready pattern 1,0,0,1,0,1 -> every beat held stable while stalled, exactly 3 handshakes, data order preserved.
- Two 2-beat packets with gap=5 on the first tlast -> tvalid low exactly 5 cycles between the packets, pkt_cnt=2.
- Four 1-beat packets, pkt_limit=2 -> exactly 2 beats sent, mem_wr_address=2 at done, pkt_cnt=2.
- start_addr=16382 with entries 16382, 16383, 0 forming one packet and entry 1 = end marker -> addresses 16382, 16383, 0, 1 in sequence; packet delivered intact.
- End marker after a tlast=0 beat -> err_trunc=1, done pulses; a second run with reset_ asserted mid-stream -> tvalid, busy and pkt_cnt go to 0 immediately, without waiting for a clock edge.
